// File: rtl/const_div_rem_pipe.sv
// Pipelined unsigned divide-by-constant: quotient and remainder, CHUNK bits folded per stage.
// Latency S stages; one global enable stalls the whole pipe while the output is held.
module const_div_rem_pipe #(
  parameter int              WIDTH   = 64,
  parameter longint unsigned DIVISOR = 23,
  parameter int              CHUNK   = 8,
  localparam int             S       = (WIDTH + CHUNK - 1) / CHUNK,
  localparam int             RW      = $clog2(DIVISOR)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic [RW-1:0]    out_r
);

  localparam int XW = S * CHUNK;
  localparam int TW = RW + CHUNK;
  localparam logic [TW-1:0] DIV_T = TW'(DIVISOR);

  if (WIDTH < 2) begin : g_bad_width
    $error("const_div_rem_pipe: WIDTH must be >= 2");
  end
  if (CHUNK < 1 || CHUNK > 16) begin : g_bad_chunk
    $error("const_div_rem_pipe: CHUNK must be in 1..16");
  end
  if (DIVISOR < 2 || (DIVISOR >> WIDTH) != 0) begin : g_bad_divisor
    $error("const_div_rem_pipe: DIVISOR must satisfy 2 <= DIVISOR < 2**WIDTH");
  end

  logic             en;
  logic [XW-1:0]    x_pad;
  logic [S-1:0]     v_q;
  logic [XW-1:0]    x_q [S];
  logic [XW-1:0]    x_d [S];
  logic [RW-1:0]    r_q [S];
  logic [RW-1:0]    r_d [S];
  logic [WIDTH-1:0] q_q [S];
  logic [WIDTH-1:0] q_d [S];

  assign en        = !out_valid | out_ready;
  assign in_ready  = en;
  assign out_valid = v_q[S-1];
  assign out_q     = q_q[S-1];
  assign out_r     = r_q[S-1];
  assign x_pad     = XW'(in_x);

  // Each stage carries the padded operand forward and folds one chunk, MSB first.
  for (genvar i = 0; i < S; i++) begin : g_stage
    logic [RW-1:0]    r_prev;
    logic [WIDTH-1:0] q_prev;
    logic [TW-1:0]    t;
    logic [CHUNK-1:0] qd;

    if (i == 0) begin : g_first
      assign x_d[i]  = x_pad;
      assign r_prev  = '0;
      assign q_prev  = '0;
    end else begin : g_next
      assign x_d[i]  = x_q[i-1];
      assign r_prev  = r_q[i-1];
      assign q_prev  = q_q[i-1];
    end

    // r_prev < DIVISOR keeps the per-stage quotient digit within CHUNK bits.
    assign t      = {r_prev, x_d[i][(S-1-i)*CHUNK +: CHUNK]};
    assign qd     = CHUNK'(t / DIV_T);
    assign r_d[i] = RW'(t % DIV_T);
    assign q_d[i] = WIDTH'({q_prev, qd});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int i = 0; i < S; i++) begin
        x_q[i] <= '0;
        r_q[i] <= '0;
        q_q[i] <= '0;
      end
    end else if (en) begin
      v_q[0] <= in_valid & in_ready;
      for (int i = 1; i < S; i++) begin
        v_q[i] <= v_q[i-1];
      end
      for (int i = 0; i < S; i++) begin
        x_q[i] <= x_d[i];
        r_q[i] <= r_d[i];
        q_q[i] <= q_d[i];
      end
    end
  end

endmodule

// File: tb/tb_const_div_rem_pipe.sv
// Directed and randomised checks of const_div_rem_pipe at defaults plus a WIDTH=61 instance.
module tb_const_div_rem_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_x;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_q;
  logic [4:0]  out_r;

  logic        in61_valid;
  logic        in61_ready;
  logic [60:0] in61_x;
  logic        out61_valid;
  logic        out61_ready;
  logic [60:0] out61_q;
  logic [4:0]  out61_r;

  int checks;
  int failures;

  const_div_rem_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_r     (out_r)
  );

  const_div_rem_pipe #(.WIDTH(61), .DIVISOR(23), .CHUNK(8)) dut61 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in61_valid),
    .in_ready  (in61_ready),
    .in_x      (in61_x),
    .out_valid (out61_valid),
    .out_ready (out61_ready),
    .out_q     (out61_q),
    .out_r     (out61_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] x);
    int g;
    in_valid = 1'b1;
    in_x     = x;
    #1;
    g = 0;
    while (!in_ready && g < 100) begin
      tick();
      #1;
      g++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL push_ready_timeout got in_ready=%b exp=1", in_ready);
    end
    tick();
  endtask

  task automatic wait_out(output int cycles);
    int g;
    g = 0;
    while (!out_valid && g < 50) begin
      tick();
      g++;
    end
    cycles = g;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; out_ready = 1'b0;
    in61_valid = 1'b0; in61_x = '0; out61_ready = 1'b1;
    #3;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (out_q !== 64'd0) begin failures++; $display("FAIL reset_out_q got=%0d exp=0", out_q); end
    checks++;
    if (out_r !== 5'd0) begin failures++; $display("FAIL reset_out_r got=%0d exp=0", out_r); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_zero_latency();
    int edges;
    out_ready = 1'b1;
    push(64'd0);
    in_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < 30) begin
      tick();
      edges++;
    end
    checks++;
    if (edges != 7) begin failures++; $display("FAIL zero_latency got=%0d edges exp=7", edges); end
    checks++;
    if (out_q !== 64'd0 || out_r !== 5'd0) begin
      failures++; $display("FAIL zero_result got q=%0d r=%0d exp q=0 r=0", out_q, out_r);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL zero_no_dup got out_valid=%b exp=0", out_valid); end
  endtask

  task automatic test_max();
    int c;
    out_ready = 1'b1;
    push(64'hFFFF_FFFF_FFFF_FFFF);
    in_valid = 1'b0;
    wait_out(c);
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL max_timeout got out_valid=%b exp=1", out_valid); end
    checks++;
    if (out_q !== 64'd802032351030850070) begin
      failures++; $display("FAIL max_q got=%0d exp=802032351030850070", out_q);
    end
    checks++;
    if (out_r !== 5'd5) begin failures++; $display("FAIL max_r got=%0d exp=5", out_r); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [63:0] eq [3];
    logic [4:0]  er [3];
    int c;
    eq[0] = 64'd1; er[0] = 5'd0;
    eq[1] = 64'd0; er[1] = 5'd22;
    eq[2] = 64'd2; er[2] = 5'd0;
    out_ready = 1'b1;
    push(64'd23);
    push(64'd22);
    push(64'd46);
    in_valid = 1'b0;
    wait_out(c);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_q !== eq[k] || out_r !== er[k]) begin
        failures++;
        $display("FAIL b2b_%0d got v=%b q=%0d r=%0d exp v=1 q=%0d r=%0d", k, out_valid, out_q, out_r, eq[k], er[k]);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_no_extra got out_valid=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) push(64'd1000 + 64'(k));
    in_valid = 1'b1;
    in_x     = 64'd555;
    #1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_q !== 64'd43 || out_r !== 5'd11) begin
        failures++;
        $display("FAIL stall_%0d got v=%b rdy=%b q=%0d r=%0d exp v=1 rdy=0 q=43 r=11", c, out_valid, in_ready, out_q, out_r);
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_q !== 64'd43 || out_r !== 5'(11 + k)) begin
        failures++;
        $display("FAIL drain_%0d got v=%b q=%0d r=%0d exp v=1 q=43 r=%0d", k, out_valid, out_q, out_r, 11 + k);
      end
      tick();
    end
    for (int c = 0; c < 10; c++) tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_no_extra got out_valid=%b exp=0", out_valid); end
  endtask

  task automatic test_random();
    logic [63:0] sb [$];
    logic [63:0] x;
    logic [63:0] ex;
    logic        acc;
    int n_in, n_out, g;
    n_in = 0; n_out = 0; g = 0;
    in_valid = 1'b0;
    x = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 5000));
    while ((n_in < 10000 || sb.size() > 0) && g < 60000) begin
      acc = 1'b0;
      if (!in_valid && n_in < 10000 && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b1;
        in_x     = x;
      end
      out_ready = (n_in >= 10000) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL rand_spurious got q=%0d r=%0d exp no result", out_q, out_r);
        end else begin
          ex = sb.pop_front();
          if (out_q !== ex / 64'd23 || out_r !== 5'(ex % 64'd23)) begin
            failures++;
            $display("FAIL rand_qr x=%0d got q=%0d r=%0d exp q=%0d r=%0d", ex, out_q, out_r, ex / 64'd23, ex % 64'd23);
          end
        end
        n_out++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(in_x);
        n_in++;
        acc = 1'b1;
      end
      tick();
      if (acc) begin
        in_valid = 1'b0;
        x = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 5000));
      end
      g++;
    end
    in_valid = 1'b0;
    checks++;
    if (n_in != n_out || sb.size() != 0) begin
      failures++;
      $display("FAIL rand_count got in=%0d out=%0d left=%0d exp equal, none left", n_in, n_out, sb.size());
    end
  endtask

  task automatic test_reset_midflight();
    int seen;
    logic [63:0] q1;
    logic [4:0]  r1;
    seen = 0; q1 = '0; r1 = '0;
    out_ready = 1'b1;
    push(64'd5);
    push(64'd6);
    push(64'd7);
    push(64'd8);
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    push(64'd100);
    in_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) begin
        if (seen == 0) begin q1 = out_q; r1 = out_r; end
        seen++;
      end
      tick();
    end
    checks++;
    if (seen != 1) begin failures++; $display("FAIL midrst_count got=%0d results exp=1", seen); end
    checks++;
    if (q1 !== 64'd4 || r1 !== 5'd8) begin
      failures++; $display("FAIL midrst_result got q=%0d r=%0d exp q=4 r=8", q1, r1);
    end
  endtask

  task automatic test_width61();
    int g;
    out61_ready = 1'b1;
    in61_valid  = 1'b1;
    in61_x      = 61'h1FFF_FFFF_FFFF_FFFF;
    #1;
    checks++;
    if (in61_ready !== 1'b1) begin failures++; $display("FAIL w61_in_ready got=%b exp=1", in61_ready); end
    tick();
    in61_valid = 1'b0;
    g = 0;
    while (!out61_valid && g < 50) begin
      tick();
      g++;
    end
    checks++;
    if (out61_valid !== 1'b1 || out61_q !== 61'd100254043878856258 || out61_r !== 5'd17) begin
      failures++;
      $display("FAIL w61_result got v=%b q=%0d r=%0d exp v=1 q=100254043878856258 r=17", out61_valid, out61_q, out61_r);
    end
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_zero_latency();
    test_max();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midflight();
    test_width61();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
